rb_seq_ctrl: RTL and testbench

- Sequencer for the 4-lane BRAM row buffer used in neighbourhood image processing.
- Accepts a raster pixel stream and generates the BRAM port controls: address, per-lane byte write enables and replicated write data.
- Tracks which lane holds the oldest row and drives the steer stage (en/sel) so the read word comes out in fixed row order.
- Flags when a full 4-row window column is valid.

---
 rtl/rb_seq_ctrl.sv | 152 +++++++++++++++
 tb/tb_rb_seq_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/rb_seq_ctrl.sv
// ----------------------------------------------------------------------------
// rb_seq_ctrl
// Sequencer for a 4-lane BRAM row buffer used in neighbourhood image
// processing. Each BRAM word holds one column of four rows, one byte per lane.
// Incoming pixels are written into the lane that holds the oldest row. Because
// the BRAM is read-first, the same access returns the previous three rows
// along with the old contents of the lane being written. The steer stage uses
// steer_sel to rotate that word into fixed row order.
//
// Ports
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   start        : one-cycle pulse, begins a frame when idle
//   busy / done  : frame in progress / one-cycle end-of-frame pulse
//   in_valid/in_ready/in_data : raster pixel stream (valid/ready)
//   out_ready    : downstream accepts the current window
//   bram_en/we/addr/wdata     : BRAM port controls (we bit k -> lane k)
//   steer_en/steer_sel        : steer stage enable and rotation
//   win_valid/win_col/win_row : window column valid, its column, newest row
// ----------------------------------------------------------------------------
module rb_seq_ctrl #(
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 480,
   parameter int ADDR_W = 10,
   parameter int ROW_W  = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        in_data,
   input  logic              out_ready,
   output logic              bram_en,
   output logic [3:0]        bram_we,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [31:0]       bram_wdata,
   output logic              steer_en,
   output logic [1:0]        steer_sel,
   output logic              win_valid,
   output logic [ADDR_W-1:0] win_col,
   output logic [ROW_W-1:0]  win_row
);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DONE} state_t;

   localparam logic [ADDR_W-1:0] COL_LAST  = ADDR_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_H - 1);
   localparam logic [ROW_W-1:0]  FILL_LAST = ROW_W'(2);

   state_t            r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_col;
   logic [ROW_W-1:0]  r_row;
   logic [1:0]        r_wr_lane;
   logic              r_win_valid;
   logic [1:0]        r_steer_sel;
   logic [ADDR_W-1:0] r_win_col;
   logic [ROW_W-1:0]  r_win_row;

   logic w_in_ready;
   logic w_accept;
   logic w_col_last;

   // A new pixel may only enter when the window slot is free or being drained
   // this cycle, so the BRAM read word is never overwritten before use.
   assign w_in_ready = ((r_state == S_FILL) || (r_state == S_RUN)) &&
                       (!r_win_valid || out_ready);
   assign w_accept   = in_valid && w_in_ready;
   assign w_col_last = (r_col == COL_LAST);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      // NOTE: default first, so every path assigns and no latch is inferred.
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (start) w_state_nxt = S_FILL;
         S_FILL: if (w_accept && w_col_last && (r_row == FILL_LAST))
                    w_state_nxt = S_RUN;
         S_RUN:  if (w_accept && w_col_last && (r_row == ROW_LAST))
                    w_state_nxt = S_DONE;
         // Wait for the final window to be taken before ending the frame.
         S_DONE: if (!r_win_valid) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ------------------------------------------------- column/row/lane
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col     <= '0;
         r_row     <= '0;
         r_wr_lane <= '0;
      end else if ((r_state == S_IDLE) && start) begin
         // Every frame starts at row 0 in lane 0.
         r_col     <= '0;
         r_row     <= '0;
         r_wr_lane <= '0;
      end else if (w_accept) begin
         if (w_col_last) begin
            r_col     <= '0;
            r_row     <= (r_row == ROW_LAST) ? '0 : r_row + ROW_W'(1);
            r_wr_lane <= r_wr_lane + 2'd1;
         end else begin
            r_col <= r_col + ADDR_W'(1);
         end
      end
   end

   // ------------------------------------------------------- window stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_win_valid <= 1'b0;
         r_steer_sel <= '0;
         r_win_col   <= '0;
         r_win_row   <= '0;
      end else if (w_accept) begin
         // The first three rows only prime the buffer; no window yet.
         r_win_valid <= (r_state == S_RUN);
         r_steer_sel <= r_wr_lane;
         r_win_col   <= r_col;
         r_win_row   <= r_row;
      end else if (out_ready) begin
         r_win_valid <= 1'b0;
      end
   end

   // ---------------------------------------------------------- outputs
   assign busy       = (r_state != S_IDLE);
   assign done       = (r_state == S_DONE) && !r_win_valid;
   assign in_ready   = w_in_ready;
   assign bram_en    = w_accept;
   assign bram_we    = w_accept ? 4'(4'b0001 << r_wr_lane) : 4'b0000;
   assign bram_addr  = w_accept ? r_col : '0;
   assign bram_wdata = w_accept ? {4{in_data}} : 32'h0;
   assign steer_en   = r_win_valid;
   assign steer_sel  = r_steer_sel;
   assign win_valid  = r_win_valid;
   assign win_col    = r_win_col;
   assign win_row    = r_win_row;

endmodule

// File: tb/tb_rb_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rb_seq_ctrl
// Self-checking bench for rb_seq_ctrl (IMG_W=4, IMG_H=6). A behavioural model
// tracks the frame as a count of accepted pixels. Column, row and lane are
// derived arithmetically from that count, and one pending-window flag is kept.
// ----------------------------------------------------------------------------
module tb_rb_seq_ctrl;
   localparam int W  = 4;
   localparam int H  = 6;
   localparam int AW = 2;
   localparam int RW = 3;
   localparam int N  = W * H;

   logic          clk = 1'b0;
   logic          rst_n, start, busy, done;
   logic          in_valid, in_ready, out_ready;
   logic [7:0]    in_data;
   logic          bram_en, steer_en, win_valid;
   logic [3:0]    bram_we;
   logic [AW-1:0] bram_addr, win_col;
   logic [31:0]   bram_wdata;
   logic [1:0]    steer_sel;
   logic [RW-1:0] win_row;

   rb_seq_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .ROW_W(RW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_ready(out_ready), .bram_en(bram_en), .bram_we(bram_we),
      .bram_addr(bram_addr), .bram_wdata(bram_wdata), .steer_en(steer_en),
      .steer_sel(steer_sel), .win_valid(win_valid), .win_col(win_col),
      .win_row(win_row)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model
   bit m_busy;
   int m_k;
   bit m_pend;
   int m_wcol, m_wrow, m_wsel;
   int wins, dut_dones;

   task automatic model_reset();
      m_busy = 0; m_k = 0; m_pend = 0;
      m_wcol = 0; m_wrow = 0; m_wsel = 0;
   endtask

   // mode: 0 plain, 1 stall 3 cycles in row 4, 2 in_valid toggling,
   //       3 last pixel accepted with out_ready=0, 4 start pulse mid-frame
   task automatic run_frame(input int vprob, input int rprob, input int mode,
                            input int abort_k, input string name);
      int cyc = 0;
      int hold = 0;
      bit ended = 0;
      logic e_rdy, e_acc, e_done;
      logic [3:0] e_we;
      logic [5:0] e_ctrl, a_ctrl;
      wins = 0; dut_dones = 0;
      while (cyc < 400) begin
         @(negedge clk);
         start     = (cyc == 0) || (mode == 4 && cyc == 9);
         in_valid  = (mode == 2) ? (cyc % 2 == 1) : ($urandom_range(99) < vprob);
         out_ready = ($urandom_range(99) < rprob);
         if (mode == 1 && m_k == 18 && m_pend && hold < 3) begin
            out_ready = 1'b0; hold++;
         end
         if (mode == 3) begin
            if (m_k == N-1 && m_pend)  in_valid  = 1'b0;
            if (m_k == N-1 && !m_pend) out_ready = 1'b0;
            if (m_k == N && hold < 3) begin out_ready = 1'b0; hold++; end
         end
         in_data = in_valid ? 8'(m_k) : 8'($urandom);
         #1;
         e_rdy  = m_busy && (m_k < N) && (!m_pend || out_ready);
         e_acc  = e_rdy && in_valid;
         e_done = m_busy && (m_k == N) && !m_pend;
         e_we   = e_acc ? 4'(1 << ((m_k / W) % 4)) : 4'b0000;
         e_ctrl = {m_busy, e_rdy, e_acc, m_pend, m_pend, e_done};
         a_ctrl = {busy, in_ready, bram_en, win_valid, steer_en, done};
         n_cmp++;
         if (a_ctrl !== e_ctrl) begin
            n_bad++;
            $display("FAIL %s ctrl cyc=%0d {busy,rdy,en,wv,sen,done} got %b want %b",
                     name, cyc, a_ctrl, e_ctrl);
         end
         n_cmp++;
         if (bram_we !== e_we) begin
            n_bad++;
            $display("FAIL %s bram_we cyc=%0d got %b want %b", name, cyc, bram_we, e_we);
         end
         if (e_acc) begin
            n_cmp++;
            if ({bram_addr, bram_wdata} !== {AW'(m_k % W), {4{8'(m_k)}}}) begin
               n_bad++;
               $display("FAIL %s bram_addr/wdata k=%0d got %0d/%h want %0d/%h", name,
                        m_k, bram_addr, bram_wdata, m_k % W, {4{8'(m_k)}});
            end
         end
         if (m_pend) begin
            n_cmp++;
            if ({win_col, win_row, steer_sel} !== {AW'(m_wcol), RW'(m_wrow), 2'(m_wsel)}) begin
               n_bad++;
               $display("FAIL %s window cyc=%0d col/row/sel got %0d/%0d/%0d want %0d/%0d/%0d",
                        name, cyc, win_col, win_row, steer_sel, m_wcol, m_wrow, m_wsel);
            end
         end
         if (done) dut_dones++;
         @(posedge clk);
         if (m_pend && out_ready) wins++;
         if (e_acc) begin
            m_pend = (m_k / W) >= 3;
            m_wcol = m_k % W;
            m_wrow = m_k / W;
            m_wsel = (m_k / W) % 4;
            m_k++;
         end else if (out_ready) begin
            m_pend = 0;
         end
         if (e_done) m_busy = 0;
         else if (start && !m_busy) begin m_busy = 1; m_k = 0; m_pend = 0; end
         cyc++;
         if (abort_k >= 0 && m_k == abort_k) break;
         if (!m_busy && cyc > 1) begin ended = 1; break; end
      end
      start = 1'b0;
      if (abort_k < 0) begin
         n_cmp++;
         if (!ended) begin
            n_bad++;
            $display("FAIL %s timeout: frame not finished within 400 cycles", name);
         end
         n_cmp++;
         if (wins != 12) begin
            n_bad++;
            $display("FAIL %s window_count got %0d want 12", name, wins);
         end
         n_cmp++;
         if (dut_dones != 1) begin
            n_bad++;
            $display("FAIL %s done_pulses got %0d want 1", name, dut_dones);
         end
      end
   endtask

   task automatic check_all_zero(input string name);
      n_cmp++;
      if ({busy, in_ready, bram_en, win_valid, steer_en, done, bram_we, bram_addr,
           bram_wdata, steer_sel, win_col, win_row} !== '0) begin
         n_bad++;
         $display("FAIL %s outputs not zero: busy=%b rdy=%b en=%b we=%b wv=%b done=%b addr=%0d sel=%0d",
                  name, busy, in_ready, bram_en, bram_we, win_valid, done, bram_addr, steer_sel);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_data = 8'hA5;
      model_reset();
      #12;
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_full_frame();
      run_frame(100, 100, 0, -1, "full_frame");
   endtask

   task automatic test_stall();
      run_frame(100, 100, 1, -1, "stall_row4");
   endtask

   task automatic test_toggle();
      run_frame(100, 100, 2, -1, "toggle_valid");
   endtask

   task automatic test_start_ignored();
      run_frame(100, 100, 4, -1, "start_mid");
   endtask

   task automatic test_last_stall();
      run_frame(100, 100, 3, -1, "last_stall");
   endtask

   task automatic test_reset_mid();
      run_frame(100, 100, 0, 10, "pre_reset");
      in_valid = 1'b1;
      #3 rst_n = 1'b0;
      #1 check_all_zero("reset_mid");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      run_frame(100, 100, 0, -1, "after_reset");
   endtask

   task automatic test_random();
      for (int i = 0; i < 4; i++) run_frame(60, 60, 0, -1, "random");
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_stall();
      test_toggle();
      test_start_ignored();
      test_last_stall();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
